// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution.
//   br_type_e  : branch class encoding on the br_type port
//   state_e    : branch_resolve FSM state encoding
//   br_flags_t : condition inputs consumed by br_cond
package branch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BR_TYPE_W  = 4;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 16;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = REG_ADDR_W'(31);

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE   = 4'd0,
    BR_BEQ    = 4'd1,
    BR_BNE    = 4'd2,
    BR_BZ     = 4'd3,
    BR_BN     = 4'd4,
    BR_BV     = 4'd5,
    BR_BLEZAL = 4'd6,
    BR_BRV    = 4'd7,
    BR_JMXOR  = 4'd8
  } br_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LINK = 1'b1
  } state_e;

  typedef struct packed {
    logic alu_zero;
    logic alu_norv;
    logic status_z;
    logic status_n;
    logic status_v;
  } br_flags_t;

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition evaluation.
//   br_type     : branch class (br_type_e encoding, unknown codes act as NONE)
//   flags       : ALU result flags and registered status flags
//   taken       : raw condition outcome (register jumps always 1; alignment handled by caller)
//   is_link     : class writes the link register when it resolves taken
//   is_reg_jump : target comes from alu_result instead of br_target
module br_cond
  import branch_pkg::*;
(
  input  logic [BR_TYPE_W-1:0] br_type,
  input  br_flags_t            flags,
  output logic                 taken,
  output logic                 is_link,
  output logic                 is_reg_jump
);

  // Class decode; defaults describe the NONE class.
  always_comb begin
    taken       = 1'b0;
    is_link     = 1'b0;
    is_reg_jump = 1'b0;
    case (br_type)
      BR_BEQ:    taken = flags.alu_zero;
      BR_BNE:    taken = ~flags.alu_zero;
      BR_BZ:     taken = flags.status_z;
      BR_BN:     taken = flags.status_n;
      BR_BV:     taken = flags.status_v;
      BR_BLEZAL: begin
        taken   = flags.alu_norv;
        is_link = 1'b1;
      end
      BR_BRV: begin
        taken       = 1'b1;
        is_reg_jump = 1'b1;
      end
      BR_JMXOR: begin
        taken       = 1'b1;
        is_link     = 1'b1;
        is_reg_jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: picks the next PC, tracks taken statistics and
// sequences the link-register write through the shared register-file port.
//   inputs : clk, rst_n, valid, br_type, pc_plus4, br_target, alu_result,
//            alu_zero, alu_norv, status_z/n/v, rf_wr_ready
//   pc_next/pc_we : combinational next-PC and its write enable
//   stall/link_we : asserted while a link write waits for the port
//   link_addr/link_data : link write destination and return address
//   taken_q/align_err/taken_cnt : taken pulse, sticky misalign, saturating count
module branch_resolve
  import branch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [BR_TYPE_W-1:0]  br_type,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [XLEN-1:0]       br_target,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_norv,
  input  logic                  status_z,
  input  logic                  status_n,
  input  logic                  status_v,
  input  logic                  rf_wr_ready,
  output logic [XLEN-1:0]       pc_next,
  output logic                  pc_we,
  output logic                  stall,
  output logic                  link_we,
  output logic [REG_ADDR_W-1:0] link_addr,
  output logic [XLEN-1:0]       link_data,
  output logic                  taken_q,
  output logic                  align_err,
  output logic [CNT_W-1:0]      taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e    state, state_next;
  br_flags_t flags;
  logic      cond_taken, is_link, is_reg_jump;
  logic      eval, misalign, take, link_req;
  logic [XLEN-1:0] target;

  assign flags = '{alu_zero: alu_zero, alu_norv: alu_norv,
                   status_z: status_z, status_n: status_n, status_v: status_v};

  br_cond u_br_cond (
    .br_type     (br_type),
    .flags       (flags),
    .taken       (cond_taken),
    .is_link     (is_link),
    .is_reg_jump (is_reg_jump)
  );

  // A misaligned register jump degrades to not-taken and never links.
  assign eval     = valid && (state == ST_IDLE);
  assign misalign = is_reg_jump && (alu_result[1:0] != 2'b00);
  assign take     = eval && cond_taken && !misalign;
  assign link_req = take && is_link;
  assign target   = is_reg_jump ? alu_result : br_target;

  // LINK holds the stage until the register file accepts the write.
  assign stall     = (state == ST_LINK);
  assign link_we   = (state == ST_LINK);
  assign link_addr = LINK_REG;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and PC selection.
  always_comb begin
    state_next = state;
    pc_we      = 1'b0;
    pc_next    = pc_plus4;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          pc_we = 1'b1;
          if (take) pc_next = target;
          if (link_req) state_next = ST_LINK;
        end
      end
      ST_LINK: begin
        if (rf_wr_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Decision side effects: taken pulse, saturating count, sticky misalign, return address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q   <= 1'b0;
      taken_cnt <= '0;
      align_err <= 1'b0;
      link_data <= '0;
    end else begin
      taken_q <= take;
      if (take && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_W'(1);
      if (eval && misalign) align_err <= 1'b1;
      if (link_req) link_data <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  br_type = 4'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_zero = 1'b0, alu_norv = 1'b0;
  logic        status_z = 1'b0, status_n = 1'b0, status_v = 1'b0;
  logic        rf_wr_ready = 1'b0;
  logic [31:0] pc_next;
  logic        pc_we, stall, link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        taken_q, align_err;
  logic [15:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state (behavioural view of the stage).
  bit          m_link;
  bit          m_tq;
  bit          m_align;
  int          m_cnt;
  logic [31:0] m_ld;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .br_type(br_type),
    .pc_plus4(pc_plus4), .br_target(br_target), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_norv(alu_norv), .status_z(status_z),
    .status_n(status_n), .status_v(status_v), .rf_wr_ready(rf_wr_ready),
    .pc_next(pc_next), .pc_we(pc_we), .stall(stall), .link_we(link_we),
    .link_addr(link_addr), .link_data(link_data), .taken_q(taken_q),
    .align_err(align_err), .taken_cnt(taken_cnt)
  );

  function automatic void model_reset();
    m_link = 0; m_tq = 0; m_align = 0; m_cnt = 0; m_ld = 32'd0;
  endfunction

  // Branch rules straight from the class table.
  function automatic void ref_eval(input logic [3:0] t, input logic [31:0] res,
                                   output bit tk, output bit lk, output bit mis);
    bit cond;
    cond = 0; mis = 0;
    case (t)
      4'd1: cond = alu_zero;
      4'd2: cond = !alu_zero;
      4'd3: cond = status_z;
      4'd4: cond = status_n;
      4'd5: cond = status_v;
      4'd6: cond = alu_norv;
      4'd7, 4'd8: begin mis = (res % 4) != 0; cond = !mis; end
      default: cond = 0;
    endcase
    tk = cond;
    lk = cond && (t == 4'd6 || t == 4'd8);
  endfunction

  function automatic logic [31:0] ref_pc();
    bit tk, lk, mis;
    ref_eval(br_type, alu_result, tk, lk, mis);
    if (valid && !m_link && tk)
      return (br_type == 4'd7 || br_type == 4'd8) ? alu_result : br_target;
    return pc_plus4;
  endfunction

  // Advance one clock and the model with it; inputs stay stable across the edge.
  task automatic tick();
    bit tk, lk, mis, was_link;
    was_link = m_link;
    ref_eval(br_type, alu_result, tk, lk, mis);
    @(posedge clk);
    if (rst_n) begin
      if (was_link) begin
        m_tq = 0;
        if (rf_wr_ready) m_link = 0;
      end else if (valid) begin
        m_tq = tk;
        if (tk && m_cnt < 65535) m_cnt++;
        if (mis) m_align = 1;
        if (lk) begin m_link = 1; m_ld = pc_plus4; end
      end else begin
        m_tq = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    valid = 0; br_type = 4'd0; alu_zero = 0; alu_norv = 0;
    status_z = 0; status_n = 0; status_v = 0; rf_wr_ready = 0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 0;
    #1 model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    valid = 1; br_type = 4'd1; alu_zero = 1; br_target = 32'h40; pc_plus4 = 32'h1004;
    #1 model_reset();
    checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL reset_pc_we: got %b want 1", pc_we); end
    checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL reset_pc_next: got %h want 00000040", pc_next); end
    @(posedge clk); #1;
    checks++; if ({stall, link_we, taken_q, align_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {stall, link_we, taken_q, align_err}); end
    checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt); end
    checks++; if (link_data !== 32'd0) begin errors++; $display("FAIL reset_link_data: got %h want 0", link_data); end
    set_idle();
    rst_n = 1;
  endtask

  task automatic test_beq();
    apply_reset();
    valid = 1; br_type = 4'd1; alu_zero = 1; br_target = 32'h40; pc_plus4 = 32'h204;
    #1;
    checks++; if (pc_next !== 32'h40 || pc_we !== 1'b1) begin errors++; $display("FAIL beq_pc: got %h/%b want 00000040/1", pc_next, pc_we); end
    tick();
    set_idle();
    checks++; if (taken_q !== 1'b1) begin errors++; $display("FAIL beq_taken_q: got %b want 1", taken_q); end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL beq_cnt: got %0d want 1", taken_cnt); end
    #1;
    checks++; if (pc_we !== 1'b0 || pc_next !== 32'h204) begin errors++; $display("FAIL idle_pc: got %h/%b want 00000204/0", pc_next, pc_we); end
  endtask

  task automatic test_blezal_link();
    apply_reset();
    valid = 1; br_type = 4'd6; alu_norv = 1; pc_plus4 = 32'h100; br_target = 32'h280;
    #1;
    checks++; if (pc_next !== 32'h280 || stall !== 1'b0) begin errors++; $display("FAIL blezal_pc: got %h stall %b want 00000280 stall 0", pc_next, stall); end
    tick();
    for (int i = 0; i < 3; i++) begin
      rf_wr_ready = (i == 2);
      #1;
      checks++; if (stall !== 1'b1 || link_we !== 1'b1) begin errors++; $display("FAIL link_hold%0d: got stall %b we %b want 1 1", i, stall, link_we); end
      checks++; if (link_data !== 32'h100 || link_addr !== 5'd31) begin errors++; $display("FAIL link_payload%0d: got %h r%0d want 00000100 r31", i, link_data, link_addr); end
      checks++; if (pc_we !== 1'b0 || pc_next !== 32'h100) begin errors++; $display("FAIL link_pc%0d: got %h/%b want 00000100/0", i, pc_next, pc_we); end
      tick();
      checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL link_cnt%0d: got %0d want 1", i, taken_cnt); end
    end
    set_idle();
    #1;
    checks++; if (stall !== 1'b0 || link_we !== 1'b0) begin errors++; $display("FAIL link_exit: got stall %b we %b want 0 0", stall, link_we); end
  endtask

  task automatic test_jmxor_misalign();
    apply_reset();
    valid = 1; br_type = 4'd1; alu_zero = 1; br_target = 32'h80; pc_plus4 = 32'h10;
    tick();
    br_type = 4'd8; alu_result = 32'h0000_0202; pc_plus4 = 32'h54;
    #1;
    checks++; if (pc_next !== 32'h54 || pc_we !== 1'b1) begin errors++; $display("FAIL jmxor_pc: got %h/%b want 00000054/1", pc_next, pc_we); end
    tick();
    set_idle();
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL jmxor_align: got %b want 1", align_err); end
    checks++; if (link_we !== 1'b0 || taken_q !== 1'b0) begin errors++; $display("FAIL jmxor_nolink: got we %b tq %b want 0 0", link_we, taken_q); end
    checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL jmxor_cnt: got %0d want 1", taken_cnt); end
    tick(); tick();
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky: got %b want 1", align_err); end
  endtask

  task automatic test_bn_bv();
    apply_reset();
    valid = 1; br_type = 4'd4; status_n = 0; status_v = 1; pc_plus4 = 32'h20; br_target = 32'h400;
    #1;
    checks++; if (pc_next !== 32'h20) begin errors++; $display("FAIL bn_pc: got %h want 00000020", pc_next); end
    tick();
    checks++; if (taken_q !== 1'b0) begin errors++; $display("FAIL bn_taken_q: got %b want 0", taken_q); end
    br_type = 4'd5;
    #1;
    checks++; if (pc_next !== 32'h400) begin errors++; $display("FAIL bv_pc: got %h want 00000400", pc_next); end
    tick();
    set_idle();
    checks++; if (taken_q !== 1'b1 || taken_cnt !== 16'd1) begin errors++; $display("FAIL bv_taken: got tq %b cnt %0d want 1 1", taken_q, taken_cnt); end
    tick();
    checks++; if (taken_q !== 1'b0) begin errors++; $display("FAIL taken_pulse: got %b want 0", taken_q); end
  endtask

  task automatic test_reset_in_link();
    apply_reset();
    valid = 1; br_type = 4'd1; alu_zero = 1; br_target = 32'h40; pc_plus4 = 32'h8;
    tick();
    br_type = 4'd8; alu_result = 32'h300; pc_plus4 = 32'h44; rf_wr_ready = 0;
    #1;
    checks++; if (pc_next !== 32'h300) begin errors++; $display("FAIL jmxor_aligned_pc: got %h want 00000300", pc_next); end
    tick();
    checks++; if (stall !== 1'b1 || link_data !== 32'h44) begin errors++; $display("FAIL pre_rst_link: got stall %b data %h want 1 00000044", stall, link_data); end
    rst_n = 0;
    #1 model_reset();
    checks++; if (stall !== 1'b0 || link_we !== 1'b0) begin errors++; $display("FAIL rst_link_drop: got stall %b we %b want 0 0", stall, link_we); end
    checks++; if (taken_cnt !== 16'd0 || link_data !== 32'd0) begin errors++; $display("FAIL rst_link_regs: got cnt %0d data %h want 0 0", taken_cnt, link_data); end
    set_idle();
    rf_wr_ready = 1;
    #1 rst_n = 1;
    tick();
    checks++; if (link_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL post_rst_link: got we %b stall %b want 0 0", link_we, stall); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      valid       = ($urandom_range(0, 9) < 8);
      br_type     = 4'($urandom_range(0, 15));
      pc_plus4    = $urandom & 32'hFFFF_FFFC;
      br_target   = $urandom & 32'hFFFF_FFFC;
      alu_result  = $urandom;
      if ($urandom_range(0, 1) == 1) alu_result[1:0] = 2'b00;
      {alu_zero, alu_norv, status_z, status_n, status_v} = 5'($urandom);
      rf_wr_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (pc_we !== (valid && !m_link)) begin errors++; $display("FAIL rnd_pc_we[%0d]: got %b want %b", i, pc_we, valid && !m_link); end
      checks++; if (pc_next !== ref_pc()) begin errors++; $display("FAIL rnd_pc_next[%0d]: got %h want %h", i, pc_next, ref_pc()); end
      checks++; if (stall !== m_link || link_we !== m_link) begin errors++; $display("FAIL rnd_stall[%0d]: got %b/%b want %b", i, stall, link_we, m_link); end
      tick();
      checks++; if (taken_q !== m_tq || align_err !== m_align) begin errors++; $display("FAIL rnd_flags[%0d]: got tq %b ae %b want %b %b", i, taken_q, align_err, m_tq, m_align); end
      checks++; if (taken_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, taken_cnt, m_cnt); end
      checks++; if (link_data !== m_ld || link_addr !== 5'd31) begin errors++; $display("FAIL rnd_link[%0d]: got %h r%0d want %h r31", i, link_data, link_addr, m_ld); end
    end
    set_idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    valid = 1; br_type = 4'd1; alu_zero = 1; br_target = 32'h40; pc_plus4 = 32'h4;
    repeat (65534) tick();
    checks++; if (taken_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", taken_cnt); end
    tick();
    checks++; if (taken_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_full: got %h want ffff", taken_cnt); end
    tick();
    checks++; if (taken_cnt !== 16'hFFFF || taken_q !== 1'b1) begin errors++; $display("FAIL sat_hold: got %h tq %b want ffff 1", taken_cnt, taken_q); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blezal_link();
    test_jmxor_misalign();
    test_bn_bv();
    test_reset_in_link();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
